// File: rtl/lsu_memctrl_if.sv
// rtl/lsu_memctrl_if.sv - request/response/RAM bundle for the load/store controller
interface lsu_memctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_address;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    // Controller side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, ram_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_address, ram_byteena, ram_data, ram_wren
    );

    // Execute stage / RAM side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, ram_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_address, ram_byteena, ram_data, ram_wren
    );
endinterface

// File: rtl/lsu_memctrl.sv
// rtl/lsu_memctrl.sv - RISC-V load/store controller for a byte-enabled registered data RAM
module lsu_memctrl #(
    parameter bit RAM_WORD_ADDR = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    lsu_memctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_READ   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_legal;
    logic        req_misaligned;
    logic        req_bad;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_result;

    assign accept = bus.req_valid && (state_q == S_IDLE);

    // Classify the incoming request: illegal width code or misaligned address
    always_comb begin
        req_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !bus.req_we;
            default:                req_legal = 1'b0;
        endcase
        req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_bad = !req_legal || req_misaligned;
    end

    // Pick the addressed lane out of the RAM word and extend it per funct3
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = bus.ram_q[7:0];
            2'd1:    lane_byte = bus.ram_q[15:8];
            2'd2:    lane_byte = bus.ram_q[23:16];
            default: lane_byte = bus.ram_q[31:24];
        endcase
        lane_half = addr_q[1] ? bus.ram_q[31:16] : bus.ram_q[15:0];
        case (funct3_q)
            3'b000:  load_result = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_result = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_result = bus.ram_q;
            3'b100:  load_result = {24'd0, lane_byte};
            3'b101:  load_result = {16'd0, lane_half};
            default: load_result = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: errors skip the RAM entirely, loads take an extra READ cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = req_bad ? S_RESP : S_ACCESS;
            S_ACCESS: state_d = we_q ? S_RESP : S_READ;
            S_READ:   state_d = S_RESP;
            S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request latch and response data registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Capture request on accept, load result in READ, clear response on handshake
    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (accept) begin
            we_d     = bus.req_we;
            funct3_d = bus.req_funct3;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            rdata_d  = 32'd0;
            err_d    = req_bad;
        end
        if (state_q == S_READ) begin
            rdata_d = load_result;
        end
        if ((state_q == S_RESP) && bus.resp_ready) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    // Outputs: RAM strobes only in ACCESS; loads never enable lanes (RAM bypasses them)
    always_comb begin
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = rdata_q;
        bus.resp_err    = err_q;
        bus.ram_address = 32'd0;
        bus.ram_byteena = 4'b0000;
        bus.ram_data    = 32'd0;
        bus.ram_wren    = 1'b0;
        case (state_q)
            S_IDLE: bus.req_ready = 1'b1;
            S_ACCESS: begin
                bus.ram_address = RAM_WORD_ADDR ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
                if (we_q) begin
                    bus.ram_wren = 1'b1;
                    case (funct3_q[1:0])
                        2'b00: begin
                            bus.ram_byteena = 4'b0001 << addr_q[1:0];
                            bus.ram_data    = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            bus.ram_byteena = addr_q[1] ? 4'b1100 : 4'b0011;
                            bus.ram_data    = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            bus.ram_byteena = 4'b1111;
                            bus.ram_data    = wdata_q;
                        end
                    endcase
                end
            end
            S_RESP: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_memctrl.sv
// tb/tb_lsu_memctrl.sv - directed self-checking bench for lsu_memctrl
module tb_lsu_memctrl;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    lsu_memctrl_if bus();

    lsu_memctrl #(.RAM_WORD_ADDR(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Byte-enabled RAM with registered read; enabled lanes bypass write data
    logic [31:0] mem [0:255];
    logic [31:0] ram_merged;

    always_comb begin
        ram_merged = mem[bus.ram_address[7:0]];
        for (int i = 0; i < 4; i++) begin
            if (bus.ram_byteena[i]) ram_merged[8*i +: 8] = bus.ram_data[8*i +: 8];
        end
    end

    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_address[7:0]] <= ram_merged;
        bus.ram_q <= ram_merged;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [31:0] r_data, r_addr, r_wdata;
    logic        r_err;
    logic [3:0]  r_be;
    int          r_lat, r_wren;

    // One request from accept to handshake; stall>0 holds resp_ready low that many cycles
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall);
        logic [31:0] held;
        @(negedge clock);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (stall == 0);
        @(posedge clock);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hDEAD_BEEF;
        bus.req_wdata  = 32'hFFFF_FFFF;
        bus.req_funct3 = 3'b111;
        r_lat = 0; r_wren = 0; r_be = 4'b0000; r_addr = 32'd0; r_wdata = 32'd0;
        do begin
            @(negedge clock);
            r_lat++;
            r_wren += int'(bus.ram_wren);
            r_be   |= bus.ram_byteena;
            if (bus.ram_address != 32'd0) r_addr = bus.ram_address;
            if (bus.ram_wren) r_wdata = bus.ram_data;
        end while (!bus.resp_valid && r_lat < 20);
        check("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
        r_data = bus.resp_rdata;
        r_err  = bus.resp_err;
        held   = bus.resp_rdata;
        for (int i = 0; i < stall; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h40;
            @(negedge clock);
            check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("stall_rdata", bus.resp_rdata, held);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            check("stall_ram_quiet", {27'd0, bus.ram_wren, bus.ram_byteena}, 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("post_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("post_rdata_clr", bus.resp_rdata, 32'd0);
        check("post_err_clr", 32'(bus.resp_err), 32'd0);
    endtask

    int seen;

    initial begin
        reset_n        = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_ram_out", {bus.ram_wren, bus.ram_byteena, 27'd0} | bus.ram_address | bus.ram_data, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);

        // SW 0x808182F3 @0x10
        run_req(1'b1, 3'b010, 32'h10, 32'h8081_82F3, 0);
        check("sw_lat", 32'(r_lat), 32'd2);
        check("sw_err", 32'(r_err), 32'd0);
        check("sw_wren_cnt", 32'(r_wren), 32'd1);
        check("sw_be", 32'(r_be), 32'hF);
        check("sw_data", r_wdata, 32'h8081_82F3);
        check("sw_addr", r_addr, 32'h4);

        // LB @0x13 -> byte 0x80 sign-extended
        run_req(1'b0, 3'b000, 32'h13, 32'd0, 0);
        check("lb_lat", 32'(r_lat), 32'd3);
        check("lb_rdata", r_data, 32'hFFFF_FF80);
        check("lb_be", 32'(r_be), 32'd0);
        check("lb_wren", 32'(r_wren), 32'd0);
        check("lb_addr", r_addr, 32'h4);

        // LBU @0x13
        run_req(1'b0, 3'b100, 32'h13, 32'd0, 0);
        check("lbu_rdata", r_data, 32'h0000_0080);
        check("lbu_be", 32'(r_be), 32'd0);

        // LH / LHU @0x12 -> halfword 0x8081
        run_req(1'b0, 3'b001, 32'h12, 32'd0, 0);
        check("lh_rdata", r_data, 32'hFFFF_8081);
        run_req(1'b0, 3'b101, 32'h12, 32'd0, 0);
        check("lhu_rdata", r_data, 32'h0000_8081);

        // SH 0x1234ABCD @0x6
        run_req(1'b1, 3'b001, 32'h6, 32'h1234_ABCD, 0);
        check("sh_be", 32'(r_be), 32'hC);
        check("sh_data", r_wdata, 32'hABCD_ABCD);
        check("sh_wren_cnt", 32'(r_wren), 32'd1);
        check("sh_addr", r_addr, 32'h1);

        // LW @0x4 with a 5-cycle response stall
        run_req(1'b0, 3'b010, 32'h4, 32'd0, 5);
        check("lw_upper", {16'd0, r_data[31:16]}, 32'h0000_ABCD);
        check("lw_err", 32'(r_err), 32'd0);

        // Misaligned and illegal requests
        run_req(1'b0, 3'b010, 32'h2, 32'd0, 0);
        check("lw_mis_err", 32'(r_err), 32'd1);
        check("lw_mis_lat", 32'(r_lat), 32'd1);
        check("lw_mis_rdata", r_data, 32'd0);
        check("lw_mis_ram", {r_wren[27:0], r_be}, 32'd0);
        run_req(1'b1, 3'b001, 32'h1, 32'h5555_5555, 0);
        check("sh_mis_err", 32'(r_err), 32'd1);
        check("sh_mis_lat", 32'(r_lat), 32'd1);
        check("sh_mis_wren", 32'(r_wren), 32'd0);
        run_req(1'b0, 3'b011, 32'h8, 32'd0, 0);
        check("ld011_err", 32'(r_err), 32'd1);
        check("ld011_rdata", r_data, 32'd0);
        run_req(1'b1, 3'b100, 32'h8, 32'd0, 0);
        check("st100_err", 32'(r_err), 32'd1);

        // Back-to-back SB then LBU
        run_req(1'b1, 3'b000, 32'h20, 32'h1234_5655, 0);
        check("sb_lat", 32'(r_lat), 32'd2);
        check("sb_be", 32'(r_be), 32'h1);
        check("sb_data", r_wdata, 32'h5555_5555);
        run_req(1'b0, 3'b100, 32'h20, 32'd0, 0);
        check("lbu20_lat", 32'(r_lat), 32'd3);
        check("lbu20_rdata", r_data, 32'h0000_0055);

        // Reset in the middle of an SW's ACCESS cycle
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'hCAFE_F00D;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        check("mid_access_wren", 32'(bus.ram_wren), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_wren", 32'(bus.ram_wren), 32'd0);
        check("rst_async_be", 32'(bus.ram_byteena), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.resp_valid) seen++;
        end
        check("rst_no_resp", 32'(seen), 32'd0);
        check("rst_rel_ready", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
